led_seq_ctrl: RTL

Command-driven sequencer for the 4-LED bank on the CPLD core board. It accepts a mode/step-count command over a valid/ready handshake and owns the tick prescaler. It drives the active-low LED outputs through the selected pattern for the requested number of ticks, then signals completion and returns to idle. It replaces free-running hard-wired rotation with a controllable engine that other logic can command.

---
 rtl/led_seq_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/led_seq_ctrl.sv
// Command-driven sequencer for the 4-LED bank (active-low LEDs) with an internal tick prescaler.
// Optional build macro LED_SEQ_PREEMPT_EN: accept a new command while RUN, aborting the current one.
module led_seq_ctrl #(
    parameter int TICK_DIV = 100000,
    parameter int CNT_W    = 17,
    parameter int STEP_W   = 8
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iCMD_VALID,
    output logic              oCMD_READY,
    input  logic [1:0]        iCMD_MODE,
    input  logic [STEP_W-1:0] iCMD_STEPS,
    output logic [3:0]        oLED,
    output logic              oBUSY,
    output logic              oDONE,
    output logic [1:0]        oDBG_STATE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ROL  = 2'b00;
    localparam logic [1:0] MODE_ROR  = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

`ifdef LED_SEQ_PREEMPT_EN
    localparam bit PREEMPT = 1'b1;
`else
    localparam bit PREEMPT = 1'b0;
`endif

    state_t              state_q, state_d;
    logic [3:0]          led_q, led_d;
    logic [CNT_W-1:0]    presc_q, presc_d;
    logic [STEP_W-1:0]   cnt_q, cnt_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic [1:0]          mode_q, mode_d;
    logic                dir_left_q, dir_left_d;
    logic                ready;
    logic                tick;

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q    <= S_IDLE;
            led_q      <= 4'b1111;
            presc_q    <= '0;
            cnt_q      <= '0;
            steps_q    <= '0;
            mode_q     <= MODE_ROL;
            dir_left_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            led_q      <= led_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            steps_q    <= steps_d;
            mode_q     <= mode_d;
            dir_left_q <= dir_left_d;
        end
    end

    // Handshake: a command transfers on any rising edge where iCMD_VALID and
    // oCMD_READY are both high; the requester holds valid/mode/steps until then.
    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        presc_d    = presc_q;
        cnt_d      = cnt_q;
        steps_d    = steps_q;
        mode_d     = mode_q;
        dir_left_d = dir_left_q;
        ready      = 1'b0;
        tick       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                led_d = 4'b1111;
                if (iCMD_VALID) begin
                    mode_d  = iCMD_MODE;
                    steps_d = iCMD_STEPS;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                presc_d    = '0;
                cnt_d      = '0;
                dir_left_d = 1'b1;
                unique case (mode_q)
                    MODE_ROL:  led_d = 4'b1110;
                    MODE_ROR:  led_d = 4'b0111;
                    MODE_PING: led_d = 4'b1110;
                    default:   led_d = 4'b0000;
                endcase
                state_d = S_RUN;
            end
            S_RUN: begin
                ready   = PREEMPT;
                tick    = (presc_q == TICK_LAST);
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    unique case (mode_q)
                        MODE_ROL: led_d = {led_q[2:0], led_q[3]};
                        MODE_ROR: led_d = {led_q[0], led_q[3:1]};
                        MODE_PING: begin
                            // Reverse on reaching an end so the end pattern is shown once.
                            if (dir_left_q) begin
                                led_d = {led_q[2:0], led_q[3]};
                                if (led_d == 4'b0111) dir_left_d = 1'b0;
                            end else begin
                                led_d = {led_q[0], led_q[3:1]};
                                if (led_d == 4'b1110) dir_left_d = 1'b1;
                            end
                        end
                        default: led_d = ~led_q;
                    endcase
                    cnt_d = cnt_q + 1'b1;
                    if (steps_q != '0 && cnt_d == steps_q) state_d = S_DONE;
                end
                // A preempting command wins over a coinciding final tick.
                if (PREEMPT && iCMD_VALID) begin
                    mode_d  = iCMD_MODE;
                    steps_d = iCMD_STEPS;
                    state_d = S_LOAD;
                end
            end
            S_DONE: begin
                led_d   = 4'b1111;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign oCMD_READY = ready;
    assign oLED       = led_q;
    assign oBUSY      = (state_q != S_IDLE);
    assign oDONE      = (state_q == S_DONE);
    assign oDBG_STATE = state_q;

endmodule
